// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared types and digit-limit constants for the real-time clock.
//   bcd_t            : one BCD digit (4 bits)
//   *_MAX constants  : largest legal value of each digit position
//   time_valid()     : checks a packed {HR_M,HR_L,MIN_M,MIN_L,SEC_M,SEC_L}
//                      time for BCD legality and 24-hour range
// -----------------------------------------------------------------------------
package rtc_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX      = 4'd5;
    localparam bcd_t MIN_TENS_MAX      = 4'd5;
    localparam bcd_t HR_MAX_TENS       = 4'd2;
    localparam bcd_t HR_MAX_UNITS_AT_2 = 4'd3;
    localparam bcd_t DIGIT_MAX         = 4'd9;

    // True when every digit is BCD and the time lies in 00:00:00..23:59:59.
    function automatic logic time_valid(input logic [23:0] t);
        bcd_t hm;
        bcd_t hl;
        bcd_t mm;
        bcd_t ml;
        bcd_t sm;
        bcd_t sl;
        logic hr_ok;
        hm = t[23:20];
        hl = t[19:16];
        mm = t[15:12];
        ml = t[11:8];
        sm = t[7:4];
        sl = t[3:0];
        hr_ok = (hm < HR_MAX_TENS && hl <= DIGIT_MAX) ||
                (hm == HR_MAX_TENS && hl <= HR_MAX_UNITS_AT_2);
        return hr_ok &&
               (mm <= MIN_TENS_MAX) && (ml <= DIGIT_MAX) &&
               (sm <= SEC_TENS_MAX) && (sl <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/rtc_bcd_counter.sv
// -----------------------------------------------------------------------------
// rtc_bcd_counter
// Two-digit BCD counter used for seconds/minutes (MODULUS=60) and hours
// (MODULUS=24).
//   clk    : clock
//   reset  : asynchronous active-low reset, clears both digits
//   en     : advance by one on this edge
//   ld     : parallel load (priority over en)
//   ld_tens/ld_units : values copied on ld (caller guarantees legality)
//   tens/units       : registered digit outputs
//   carry  : combinational, high when en is set and the counter is at its top
//            value, so the next stage advances on the very same edge
// -----------------------------------------------------------------------------
module rtc_bcd_counter
    import rtc_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic ld,
    input  bcd_t ld_tens,
    input  bcd_t ld_units,
    output bcd_t tens,
    output bcd_t units,
    output logic carry
);

    // Top value is 59 for a 60-modulus counter and 23 for hours.
    localparam bcd_t TENS_TOP  = (MODULUS == 24) ? HR_MAX_TENS : MIN_TENS_MAX;
    localparam bcd_t UNITS_TOP = (MODULUS == 24) ? HR_MAX_UNITS_AT_2 : DIGIT_MAX;

    bcd_t tens_r;
    bcd_t units_r;
    bcd_t tens_nxt_s;
    bcd_t units_nxt_s;
    logic at_top_s;

    assign at_top_s = (tens_r == TENS_TOP) && (units_r == UNITS_TOP);
    assign carry    = en && at_top_s;
    assign tens     = tens_r;
    assign units    = units_r;

    // Next-state selection: load, wrap at top, units rollover, or increment.
    always_comb begin
        tens_nxt_s  = tens_r;
        units_nxt_s = units_r;
        if (ld) begin
            tens_nxt_s  = ld_tens;
            units_nxt_s = ld_units;
        end else if (en) begin
            if (at_top_s) begin
                tens_nxt_s  = 4'd0;
                units_nxt_s = 4'd0;
            end else if (units_r >= DIGIT_MAX) begin
                tens_nxt_s  = tens_r + 4'd1;
                units_nxt_s = 4'd0;
            end else begin
                tens_nxt_s  = tens_r;
                units_nxt_s = units_r + 4'd1;
            end
        end else begin
            tens_nxt_s  = tens_r;
            units_nxt_s = units_r;
        end
    end

    // Digit registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tens_r  <= 4'd0;
            units_r <= 4'd0;
        end else begin
            tens_r  <= tens_nxt_s;
            units_r <= units_nxt_s;
        end
    end

endmodule

// File: rtl/rtc_top.sv
// -----------------------------------------------------------------------------
// rtc_top
// 24-hour BCD real-time clock: prescaler, seconds/minutes/hours counters with
// a same-edge carry chain, and an optional time-load path.
//   Parameter TICKS_PER_SEC : clk edges per one-second advance (1..2^26)
//   clk        : clock
//   reset      : asynchronous active-low reset, clears time and prescaler
//   load       : (RTC_LOAD_EN only) load request, priority over counting
//   load_time  : (RTC_LOAD_EN only) {HR_M,HR_L,MIN_M,MIN_L,SEC_M,SEC_L};
//                an illegal time is ignored and counting continues
//   HR_M..SEC_L: registered BCD digits
// Build option: define RTC_LOAD_EN to include the load ports.
// -----------------------------------------------------------------------------
module rtc_top
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef RTC_LOAD_EN
    input  logic        load,
    input  logic [23:0] load_time,
`endif
    output logic [3:0]  HR_M,
    output logic [3:0]  HR_L,
    output logic [3:0]  MIN_M,
    output logic [3:0]  MIN_L,
    output logic [3:0]  SEC_M,
    output logic [3:0]  SEC_L
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_r;
    logic          sec_tick_s;
    logic          load_ok_s;
    logic [23:0]   load_time_s;
    logic          sec_carry_s;
    logic          min_carry_s;
    logic          day_wrap_unused_s;

`ifdef RTC_LOAD_EN
    // A load request is honoured only for a legal BCD 24-hour time.
    assign load_ok_s   = load && time_valid(load_time);
    assign load_time_s = load_time;
`else
    assign load_ok_s   = 1'b0;
    assign load_time_s = 24'h00_0000;
`endif

    assign sec_tick_s = (presc_r == PRESC_LAST);

    // Prescaler: counts 0..TICKS_PER_SEC-1; a load restarts the second.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= {PW{1'b0}};
        end else if (load_ok_s || sec_tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    rtc_bcd_counter #(.MODULUS(60)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .en       (sec_tick_s),
        .ld       (load_ok_s),
        .ld_tens  (load_time_s[7:4]),
        .ld_units (load_time_s[3:0]),
        .tens     (SEC_M),
        .units    (SEC_L),
        .carry    (sec_carry_s)
    );

    rtc_bcd_counter #(.MODULUS(60)) u_min (
        .clk      (clk),
        .reset    (reset),
        .en       (sec_carry_s),
        .ld       (load_ok_s),
        .ld_tens  (load_time_s[15:12]),
        .ld_units (load_time_s[11:8]),
        .tens     (MIN_M),
        .units    (MIN_L),
        .carry    (min_carry_s)
    );

    rtc_bcd_counter #(.MODULUS(24)) u_hr (
        .clk      (clk),
        .reset    (reset),
        .en       (min_carry_s),
        .ld       (load_ok_s),
        .ld_tens  (load_time_s[23:20]),
        .ld_units (load_time_s[19:16]),
        .tens     (HR_M),
        .units    (HR_L),
        .carry    (day_wrap_unused_s)
    );

endmodule

// File: tb/tb_rtc_top.sv
// -----------------------------------------------------------------------------
// tb_rtc_top
// Directed bench for rtc_top. Three instances share one clock:
//   u_dut  : default rate, follows a full day from reset
//   u_dut_b: default rate, own reset; reset mid-count at 12:34:56 and, when
//            RTC_LOAD_EN is defined, receives the load vectors
//   u_dut4 : TICKS_PER_SEC=4
// -----------------------------------------------------------------------------
module tb_rtc_top;

    logic clk = 1'b0;
    logic rst_main;
    logic rst_b;

    logic [3:0] a_hm, a_hl, a_mm, a_ml, a_sm, a_sl;
    logic [3:0] b_hm, b_hl, b_mm, b_ml, b_sm, b_sl;
    logic [3:0] c_hm, c_hl, c_mm, c_ml, c_sm, c_sl;
    logic [23:0] t_a, t_b, t_c;

`ifdef RTC_LOAD_EN
    logic        load_b;
    logic [23:0] load_time_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int e       = 0;

    assign t_a = {a_hm, a_hl, a_mm, a_ml, a_sm, a_sl};
    assign t_b = {b_hm, b_hl, b_mm, b_ml, b_sm, b_sl};
    assign t_c = {c_hm, c_hl, c_mm, c_ml, c_sm, c_sl};

    always #5 clk = ~clk;

    rtc_top u_dut (
        .clk       (clk),
        .reset     (rst_main),
`ifdef RTC_LOAD_EN
        .load      (1'b0),
        .load_time (24'h00_0000),
`endif
        .HR_M (a_hm), .HR_L (a_hl), .MIN_M (a_mm), .MIN_L (a_ml),
        .SEC_M (a_sm), .SEC_L (a_sl)
    );

    rtc_top u_dut_b (
        .clk       (clk),
        .reset     (rst_b),
`ifdef RTC_LOAD_EN
        .load      (load_b),
        .load_time (load_time_b),
`endif
        .HR_M (b_hm), .HR_L (b_hl), .MIN_M (b_mm), .MIN_L (b_ml),
        .SEC_M (b_sm), .SEC_L (b_sl)
    );

    rtc_top #(.TICKS_PER_SEC(4)) u_dut4 (
        .clk       (clk),
        .reset     (rst_main),
`ifdef RTC_LOAD_EN
        .load      (1'b0),
        .load_time (24'h00_0000),
`endif
        .HR_M (c_hm), .HR_L (c_hl), .MIN_M (c_mm), .MIN_L (c_ml),
        .SEC_M (c_sm), .SEC_L (c_sl)
    );

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        e += n;
    endtask

    task automatic advance_to(input int target);
        step(target - e);
    endtask

    initial begin
        rst_main = 1'b1;
        rst_b    = 1'b1;
`ifdef RTC_LOAD_EN
        load_b      = 1'b0;
        load_time_b = 24'h00_0000;
`endif
        // Reset asserted before the first clock edge: must clear at once.
        #2;
        rst_main = 1'b0;
        rst_b    = 1'b0;
        #1;
        check("async_reset_a", t_a, 24'h00_0000);
        check("async_reset_b", t_b, 24'h00_0000);
        check("async_reset_c", t_c, 24'h00_0000);

        // Held in reset across two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold_a", t_a, 24'h00_0000);
        check("reset_hold_c", t_c, 24'h00_0000);

        rst_main = 1'b1;
        rst_b    = 1'b1;
        #1;
        check("release_a", t_a, 24'h00_0000);

        step(1);
        check("first_edge_a", t_a, 24'h00_0001);
        check("first_edge_b", t_b, 24'h00_0001);
        check("tps4_edge1", t_c, 24'h00_0000);

        // Divide-by-4 instance: seconds = floor(edges/4).
        for (int k = 2; k <= 8; k++) begin
            step(1);
            check($sformatf("tps4_edge%0d", k), t_c, 24'(k / 4));
        end
        check("edge8_a", t_a, 24'h00_0008);

        advance_to(60);
        check("min_carry", t_a, 24'h00_0100);
        advance_to(3600);
        check("hour_carry", t_a, 24'h01_0000);
        advance_to(36000);
        check("hour_09_to_10", t_a, 24'h10_0000);

        advance_to(45296);
        check("b_at_123456", t_b, 24'h12_3456);
        rst_b = 1'b0;
        #1;
        check("async_reset_mid", t_b, 24'h00_0000);
        check("other_unaffected", t_a, 24'h12_3456);
        step(1);
        check("reset_mid_hold", t_b, 24'h00_0000);
        rst_b = 1'b1;
        step(1);
        check("b_restart", t_b, 24'h00_0001);
        check("a_at_123458", t_a, 24'h12_3458);

`ifdef RTC_LOAD_EN
        load_b      = 1'b1;
        load_time_b = 24'h23_5958;
        step(1);
        check("load_valid", t_b, 24'h23_5958);
        load_b = 1'b0;
        step(2);
        check("load_then_wrap", t_b, 24'h00_0000);
        load_b      = 1'b1;
        load_time_b = 24'h24_0000;
        step(1);
        check("load_hr24_ignored", t_b, 24'h00_0001);
        load_time_b = 24'h00_005A;
        step(1);
        check("load_nonbcd_ignored", t_b, 24'h00_0002);
        load_time_b = 24'h00_6000;
        step(1);
        check("load_min60_ignored", t_b, 24'h00_0003);
        load_b = 1'b0;
`endif

        advance_to(71999);
        check("at_195959", t_a, 24'h19_5959);
        advance_to(72000);
        check("hour_19_to_20", t_a, 24'h20_0000);
        advance_to(86399);
        check("at_235959", t_a, 24'h23_5959);
        advance_to(86400);
        check("day_wrap", t_a, 24'h00_0000);
        check("tps4_six_hours", t_c, 24'h06_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_top.md
RTC_TOP -- requirements
Module: rtc_top

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1, number of clk rising edges per one-second advance; legal range 1..2^26.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 HR_M  output  4  hours tens digit, BCD 0..2.
REQ-005 HR_L  output  4  hours units digit, BCD 0..9 (0..3 when HR_M=2).
REQ-006 MIN_M  output  4  minutes tens digit, BCD 0..5.
REQ-007 MIN_L  output  4  minutes units digit, BCD 0..9.
REQ-008 SEC_M  output  4  seconds tens digit, BCD 0..5.
REQ-009 SEC_L  output  4  seconds units digit, BCD 0..9.
REQ-010 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Function
REQ-011 Timekeeping SHALL be a 24-hour clock spanning 00:00:00..23:59:59, held as six BCD digit registers; no binary-to-BCD conversion.
REQ-012 Prescaler SHALL count 0..TICKS_PER_SEC-1 and assert an internal one-cycle sec_tick on the edge where the count equals TICKS_PER_SEC-1, then wrap to 0; with TICKS_PER_SEC=1, sec_tick SHALL be high every cycle.
REQ-013 On a clk edge with sec_tick high, SEC_L SHALL increment; 9 SHALL wrap to 0 and carry into SEC_M.
REQ-014 SEC_M:SEC_L at 59 SHALL wrap to 00 and carry into MIN_L; minutes SHALL follow the same 0..59 rule with carry into HR_L.
REQ-015 Hours SHALL wrap from 09 to 10 and from 19 to 20; 23 SHALL wrap to 00.
REQ-016 At 23:59:59 plus one tick, all six digits SHALL become 0 in the same cycle.
REQ-017 All carries SHALL resolve within the same clock edge, with no ripple latency between digits.
REQ-018 Each digit register SHALL hold its value when sec_tick is low.
REQ-019 Digits SHALL never hold non-BCD or out-of-range values in any reachable state.

Reset
REQ-020 While reset=0, all six digits and the prescaler SHALL be 0 immediately, without waiting for a clk edge.
REQ-021 Assertion of reset mid-count SHALL discard the current time.
REQ-022 After reset returns to 1, the first sec_tick SHALL occur on the TICKS_PER_SEC-th rising edge; with the default, the first edge yields 00:00:01.

Configuration
REQ-023 Macro RTC_LOAD_EN SHALL compile in ports load (input, 1) and load_time (input, 24, digits {HR_M,HR_L,MIN_M,MIN_L,SEC_M,SEC_L} from MSB).
REQ-024 With RTC_LOAD_EN defined, load=1 at a rising edge SHALL copy load_time into the digits and clear the prescaler; load SHALL take priority over sec_tick.
REQ-025 A load_time that is invalid (any non-BCD digit, hours>23, minutes>59 or seconds>59) SHALL be ignored entirely, and normal counting SHALL continue.
REQ-026 With RTC_LOAD_EN undefined, the load ports SHALL be absent and the clock SHALL be free-running only.

Structure
REQ-027 Package rtc_pkg SHALL hold the digit-limit constants (SEC_TENS_MAX=5, MIN_TENS_MAX=5, HR_MAX_TENS=2, HR_MAX_UNITS_AT_2=3, DIGIT_MAX=9) and a 4-bit bcd_t typedef.
REQ-028 Sub-module rtc_bcd_counter (two-digit BCD counter with enable, carry-out and modulus parameter 60 or 24) SHALL be instantiated three times, for seconds, minutes and hours.
REQ-029 rtc_top SHALL contain the prescaler, the carry chain and the optional load logic.

Verification
REQ-030 Hold reset=0 for 2 edges, then release: outputs 00:00:00, and 00:00:01 after the first edge.
REQ-031 From reset, 60 edges -> 00:01:00; 3600 edges -> 01:00:00; 36000 edges -> 10:00:00.
REQ-032 From reset, 86399 edges -> 23:59:59; the next edge -> 00:00:00.
REQ-033 At 12:34:56, drive reset=0 between edges: all outputs read 0 before the next clk edge.
REQ-034 With TICKS_PER_SEC=4, 8 edges after reset -> 00:00:02, with SEC_L stable for each 4-edge window.
REQ-035 With RTC_LOAD_EN defined: load 23:59:58 then 2 edges -> 00:00:00; load 24:00:00 -> ignored, time continues incrementing.
